// File: rtl/multiplier_datapath_taint_track_bitwise_if.sv
// Strobe/operand bundle between the multiplier controller and its shift-add datapath,
// with a shadow taint bit carried alongside every data and strobe bit.
interface multiplier_datapath_taint_track_bitwise_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0]   mdIn, mdIn_t;
  logic [WIDTH-1:0]   mrIn, mrIn_t;
  logic               mdld, mdld_t;
  logic               mrld, mrld_t;
  logic               rsclear, rsclear_t;
  logic               rsload, rsload_t;
  logic               rsshr, rsshr_t;
  logic [WIDTH-1:0]   multiplierReg, multiplierReg_t;
  logic [2*WIDTH-1:0] product, product_t;

  modport master (
    output mdIn, mdIn_t, mrIn, mrIn_t, mdld, mdld_t, mrld, mrld_t,
           rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
    input  multiplierReg, multiplierReg_t, product, product_t
  );

  modport slave (
    input  mdIn, mdIn_t, mrIn, mrIn_t, mdld, mdld_t, mrld, mrld_t,
           rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
    output multiplierReg, multiplierReg_t, product, product_t
  );
endinterface

// File: rtl/multiplier_datapath_taint_track_bitwise.sv
// Shift-add multiplier datapath with bitwise taint tracking on MD, MR, P and carry C.
// Define MDP_PRECISE_TAINT_EN for value-aware taint on tainted strobes; otherwise they taint the whole destination.
module multiplier_datapath_taint_track_bitwise #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  multiplier_datapath_taint_track_bitwise_if.slave bus
);

  localparam int PW = 2*WIDTH + 1;

  logic [WIDTH-1:0] md_q, md_d, md_t_q, md_t_d;
  logic [WIDTH-1:0] mr_q, mr_d, mr_t_q, mr_t_d;
  logic [PW-1:0]    cp_q, cp_d, cp_t_q, cp_t_d;
  logic [2:0]       strobe, strobe_t;
  logic [2*PW-1:0]  act;
`ifdef MDP_PRECISE_TAINT_EN
  logic [2*PW-1:0]  alt;
  logic [2:0]       combo;
`endif

  assign strobe   = {bus.rsclear,   bus.rsload,   bus.rsshr};
  assign strobe_t = {bus.rsclear_t, bus.rsload_t, bus.rsshr_t};

  // Outcome {value, taint} of {C,P} for one strobe pattern; op = {clear, load, shift}.
  function automatic logic [2*PW-1:0] p_op(
    input logic [2:0]       op,
    input logic [PW-1:0]    cp,
    input logic [PW-1:0]    cpt,
    input logic [WIDTH-1:0] md,
    input logic [WIDTH-1:0] mdt
  );
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  sum_t;
    logic            acc;
    logic [PW-1:0]   v;
    logic [PW-1:0]   t;
    v     = cp;
    t     = cpt;
    sum   = '0;
    sum_t = '0;
    acc   = 1'b0;
    if (op[2]) begin
      v = '0;
      t = '0;
    end else if (op[1]) begin
      sum = {1'b0, cp[2*WIDTH-1:WIDTH]} + {1'b0, md};
      for (int i = 0; i < WIDTH; i++) begin
        acc      = acc | cpt[WIDTH+i] | mdt[i];
        sum_t[i] = acc;
      end
      sum_t[WIDTH] = acc;
      v = {sum, cp[WIDTH-1:0]};
      t = {sum_t, cpt[WIDTH-1:0]};
    end else if (op[0]) begin
      v = {1'b0, cp[PW-1:1]};
      t = {1'b0, cpt[PW-1:1]};
    end
    return {v, t};
  endfunction

  always_comb begin
    md_d = bus.mdld ? bus.mdIn : md_q;
    mr_d = bus.mrld ? bus.mrIn : mr_q;
`ifdef MDP_PRECISE_TAINT_EN
    md_t_d = bus.mdld_t ? (bus.mdIn_t | md_t_q | (bus.mdIn ^ md_q))
                        : (bus.mdld ? bus.mdIn_t : md_t_q);
    mr_t_d = bus.mrld_t ? (bus.mrIn_t | mr_t_q | (bus.mrIn ^ mr_q))
                        : (bus.mrld ? bus.mrIn_t : mr_t_q);
`else
    md_t_d = bus.mdld_t ? '1 : (bus.mdld ? bus.mdIn_t : md_t_q);
    mr_t_d = bus.mrld_t ? '1 : (bus.mrld ? bus.mrIn_t : mr_t_q);
`endif

    act    = p_op(strobe, cp_q, cp_t_q, md_q, md_t_q);
    cp_d   = act[2*PW-1:PW];
    cp_t_d = act[PW-1:0];
`ifdef MDP_PRECISE_TAINT_EN
    // Merge every strobe pattern reachable by flipping tainted strobes, losers included.
    for (int k = 0; k < 8; k++) begin
      combo = 3'(k);
      alt   = '0;
      if (((combo ^ strobe) & ~strobe_t) == 3'b000) begin
        alt    = p_op(combo, cp_q, cp_t_q, md_q, md_t_q);
        cp_t_d = cp_t_d | alt[PW-1:0] | (alt[2*PW-1:PW] ^ cp_d);
      end
    end
`else
    if (|strobe_t) cp_t_d = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_q   <= '0;
      md_t_q <= '0;
      mr_q   <= '0;
      mr_t_q <= '0;
      cp_q   <= '0;
      cp_t_q <= '0;
    end else begin
      md_q   <= md_d;
      md_t_q <= md_t_d;
      mr_q   <= mr_d;
      mr_t_q <= mr_t_d;
      cp_q   <= cp_d;
      cp_t_q <= cp_t_d;
    end
  end

  assign bus.multiplierReg   = mr_q;
  assign bus.multiplierReg_t = mr_t_q;
  assign bus.product         = cp_q[2*WIDTH-1:0];
  assign bus.product_t       = cp_t_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_datapath_taint_track_bitwise.sv
// Scoreboard bench for the taint-tracking multiplier datapath: directed scenarios plus random strobes.
module tb_multiplier_datapath_taint_track_bitwise;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiplier_datapath_taint_track_bitwise_if #(.WIDTH(4)) bus ();

  multiplier_datapath_taint_track_bitwise #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] mdi, mdit, mri, mrit;
    logic       mdld, mdldt, mrld, mrldt;
    logic       clr, clrt, ld, ldt, shr, shrt;
  } stim_t;

  typedef struct {
    int         tag;
    logic [3:0] mr, mrt;
    logic [7:0] p, pt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // reference state: {C,P} held as one 9-bit number
  logic [3:0] m_md, m_mdt, m_mr, m_mrt;
  logic [8:0] m_p, m_pt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // op: 0 hold, 1 shift, 2 add, 3 clear
  task automatic p_result(input int op, output logic [8:0] v, output logic [8:0] t);
    int         s;
    logic [3:0] up_t;
    v = m_p;
    t = m_pt;
    case (op)
      1: begin v = m_p >> 1; t = m_pt >> 1; end
      2: begin
        s    = int'(m_p[7:4]) + int'(m_md);
        v    = 9'((s << 4) | int'(m_p[3:0]));
        up_t = m_pt[7:4];
        for (int i = 0; i < 4; i++)
          t[4+i] = ((int'(up_t | m_mdt) & ((1 << (i+1)) - 1)) != 0);
        t[8] = ((up_t | m_mdt) != 4'h0);
      end
      3: begin v = '0; t = '0; end
      default: ;
    endcase
  endtask

  task automatic model_step(input stim_t s);
    logic [8:0] av, at, ov, ot, nt;
    logic       poss [4];
    int         win;
    logic [3:0] nmd, nmdt, nmr, nmrt;
    if (s.rst) begin
      m_md = '0; m_mdt = '0; m_mr = '0; m_mrt = '0; m_p = '0; m_pt = '0;
      return;
    end
    poss[3] = s.clr | s.clrt;
    poss[2] = (!s.clr | s.clrt) & (s.ld | s.ldt);
    poss[1] = (!s.clr | s.clrt) & (!s.ld | s.ldt) & (s.shr | s.shrt);
    poss[0] = (!s.clr | s.clrt) & (!s.ld | s.ldt) & (!s.shr | s.shrt);
    win = s.clr ? 3 : s.ld ? 2 : s.shr ? 1 : 0;
    p_result(win, av, at);
    nt = at;
`ifdef MDP_PRECISE_TAINT_EN
    for (int op = 0; op < 4; op++)
      if (poss[op]) begin
        p_result(op, ov, ot);
        nt |= ot | (ov ^ av);
      end
`else
    if (s.clrt | s.ldt | s.shrt) nt = '1;
`endif
    nmd  = s.mdld ? s.mdi : m_md;
    nmr  = s.mrld ? s.mri : m_mr;
`ifdef MDP_PRECISE_TAINT_EN
    nmdt = s.mdldt ? (s.mdit | m_mdt | (s.mdi ^ m_md)) : (s.mdld ? s.mdit : m_mdt);
    nmrt = s.mrldt ? (s.mrit | m_mrt | (s.mri ^ m_mr)) : (s.mrld ? s.mrit : m_mrt);
`else
    nmdt = s.mdldt ? 4'hF : (s.mdld ? s.mdit : m_mdt);
    nmrt = s.mrldt ? 4'hF : (s.mrld ? s.mrit : m_mrt);
`endif
    m_p = av; m_pt = nt;
    m_md = nmd; m_mdt = nmdt; m_mr = nmr; m_mrt = nmrt;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    rst           = s.rst;
    bus.mdIn      = s.mdi;  bus.mdIn_t    = s.mdit;
    bus.mrIn      = s.mri;  bus.mrIn_t    = s.mrit;
    bus.mdld      = s.mdld; bus.mdld_t    = s.mdldt;
    bus.mrld      = s.mrld; bus.mrld_t    = s.mrldt;
    bus.rsclear   = s.clr;  bus.rsclear_t = s.clrt;
    bus.rsload    = s.ld;   bus.rsload_t  = s.ldt;
    bus.rsshr     = s.shr;  bus.rsshr_t   = s.shrt;
    model_step(s);
    e.tag = cyc + 1;
    e.mr  = m_mr;  e.mrt = m_mrt;
    e.p   = m_p[7:0]; e.pt = m_pt[7:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // monitor: outputs are register values, so each entry is due at the edge it was tagged for
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        chk("sb_mr",   8'(bus.multiplierReg),   8'(e.mr));
        chk("sb_mr_t", 8'(bus.multiplierReg_t), 8'(e.mrt));
        chk("sb_p",    bus.product,             e.p);
        chk("sb_p_t",  bus.product_t,           e.pt);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    s = '0; s.rst = 1'b1;
    drive(s); drive(s);
    chk("reset_p", bus.product, 8'h00);
    chk("reset_mr", 8'(bus.multiplierReg), 8'h00);

    // 1: 5 x 3
    s = '0; s.mrld = 1; s.mri = 4'd3; s.mdld = 1; s.mdi = 4'd5; s.clr = 1; drive(s);
    s = '0; s.ld = 1; drive(s);
    s = '0; s.shr = 1; drive(s);
    s = '0; s.ld = 1; drive(s);
    s = '0; s.shr = 1; drive(s); drive(s); drive(s);
    chk("t1_product", bus.product, 8'h0F);
    chk("t1_product_t", bus.product_t, 8'h00);

    // 2: carry into C and back in on shift
    s = '0; s.mdld = 1; s.mdi = 4'hF; s.clr = 1; drive(s);
    s = '0; s.ld = 1; drive(s);
    chk("t2_pre", bus.product, 8'hF0);
    drive(s);
    chk("t2_add", bus.product, 8'hE0);
    s = '0; s.shr = 1; drive(s);
    chk("t2_shift", bus.product, 8'hF0);

    // 3: adder taint
    s = '0; s.mdld = 1; s.mdi = 4'h4; s.mdit = 4'b0100; s.clr = 1; drive(s);
    s = '0; s.ld = 1; drive(s);
    chk("t3_add_t", bus.product_t, 8'b1100_0000);
    s = '0; s.shr = 1; drive(s);
    chk("t3_shift_t", bus.product_t, 8'b1110_0000);

    // 5: reset wins over a strobe
    s = '0; s.rst = 1; s.ld = 1; drive(s);
    chk("t5_p", bus.product, 8'h00);
    chk("t5_p_t", bus.product_t, 8'h00);
    chk("t5_mr_t", 8'(bus.multiplierReg_t), 8'h00);

    // 4: tainted load strobe
    s = '0; s.mrld = 1; s.mri = 4'b1010; drive(s);
    s = '0; s.mrld = 1; s.mri = 4'b1001; s.mrldt = 1; drive(s);
    chk("t4_mr", 8'(bus.multiplierReg), 8'h09);
`ifdef MDP_PRECISE_TAINT_EN
    chk("t4_mr_t", 8'(bus.multiplierReg_t), 8'h03);
`else
    chk("t4_mr_t", 8'(bus.multiplierReg_t), 8'h0F);
`endif

    // 6: clear beats add and shift
    s = '0; s.mdld = 1; s.mdi = 4'hB; s.clr = 1; drive(s);
    s = '0; s.ld = 1; drive(s);
    s = '0; s.shr = 1; drive(s); drive(s); drive(s); drive(s);
    s = '0; s.mdld = 1; s.mdi = 4'hA; drive(s);
    s = '0; s.ld = 1; drive(s);
    chk("t6_pre", bus.product, 8'hAB);
    s = '0; s.clr = 1; s.ld = 1; s.shr = 1; drive(s);
    chk("t6_prio", bus.product, 8'h00);

    // random strobes, sparse taint so it does not saturate
    for (int n = 0; n < 500; n++) begin
      s       = '0;
      s.rst   = ($urandom_range(49) == 0);
      s.mdi   = 4'($urandom);
      s.mri   = 4'($urandom);
      s.mdit  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      s.mrit  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      s.mdld  = 1'($urandom);
      s.mrld  = 1'($urandom);
      s.clr   = ($urandom_range(5) == 0);
      s.ld    = 1'($urandom);
      s.shr   = 1'($urandom);
      s.mdldt = ($urandom_range(9) == 0);
      s.mrldt = ($urandom_range(9) == 0);
      s.clrt  = ($urandom_range(11) == 0);
      s.ldt   = ($urandom_range(11) == 0);
      s.shrt  = ($urandom_range(11) == 0);
      drive(s);
    end

    s = '0;
    drive(s); drive(s);
    @(negedge clk); #1;
    chk("sb_drain", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
